id_ex_stage: RTL and testbench

- ID/EX pipeline stage of the 5-stage 16-bit datapath, directly downstream of the 16x16 register file.
- Captures both register-file read operands and the decoded control word.
- Resolves RAW hazards by forwarding from the MEM and WB stages, and detects load-use hazards, stalling the front end and inserting a bubble.
- Handles branch flush and an external pipeline hold.

---
 rtl/pipe_pkg.sv | 41 ++++
 rtl/operand_fwd_mux.sv | 51 +++++
 rtl/id_ex_stage.sv | 169 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, ALU opcodes and control-word types for the
// 16-bit five-stage pipeline.
package pipe_pkg;

  localparam int DW  = 16;
  localparam int RW  = 4;
  localparam int OPW = 4;

  localparam logic [OPW-1:0] ALU_ADD = 4'h0;
  localparam logic [OPW-1:0] ALU_SUB = 4'h1;
  localparam logic [OPW-1:0] ALU_AND = 4'h2;
  localparam logic [OPW-1:0] ALU_OR  = 4'h3;
  localparam logic [OPW-1:0] ALU_XOR = 4'h4;
  localparam logic [OPW-1:0] ALU_SLL = 4'h5;
  localparam logic [OPW-1:0] ALU_SRL = 4'h6;
  localparam logic [OPW-1:0] ALU_SRA = 4'h7;
  localparam logic [OPW-1:0] ALU_SLT = 4'h8;
  localparam logic [OPW-1:0] ALU_MOV = 4'h9;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_MEM,
    FWD_WB1,
    FWD_WB2
  } fwd_sel_e;

  typedef struct packed {
    logic           reg_write;
    logic           write_op2;
    logic           mem_read;
    logic           mem_write;
    logic [OPW-1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t ctrl_bubble();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand bypass: picks the youngest in-flight writer of rs,
// falling back to register-file data.
module operand_fwd_mux
  import pipe_pkg::*;
(
  input  logic [RW-1:0] rs_i,
  input  logic [DW-1:0] rf_data_i,
  input  logic          mem_valid_i,
  input  logic          mem_reg_write_i,
  input  logic [RW-1:0] mem_rd_i,
  input  logic [DW-1:0] mem_result_i,
  input  logic          wb_valid_i,
  input  logic          wb_reg_write_i,
  input  logic          wb_write_op2_i,
  input  logic [RW-1:0] wb_rd1_i,
  input  logic [RW-1:0] wb_rd2_i,
  input  logic [DW-1:0] wb_data1_i,
  input  logic [DW-1:0] wb_data2_i,
  output logic [DW-1:0] data_o
);

  logic     hit_mem;
  logic     hit_wb1;
  logic     hit_wb2;
  fwd_sel_e sel;

  assign hit_mem = mem_valid_i & mem_reg_write_i
                 & (mem_rd_i == rs_i);
  assign hit_wb1 = wb_valid_i & wb_reg_write_i
                 & (wb_rd1_i == rs_i);
  assign hit_wb2 = wb_valid_i & wb_reg_write_i
                 & wb_write_op2_i & (wb_rd2_i == rs_i);

  always_comb begin
    sel = FWD_RF;
    if (hit_mem)      sel = FWD_MEM;
    else if (hit_wb1) sel = FWD_WB1;
    else if (hit_wb2) sel = FWD_WB2;
  end

  always_comb begin
    data_o = rf_data_i;
    unique case (sel)
      FWD_MEM: data_o = mem_result_i;
      FWD_WB1: data_o = wb_data1_i;
      FWD_WB2: data_o = wb_data2_i;
      default: data_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX stage register with operand forwarding, load-use stall,
// branch flush and external hold.
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [RW-1:0]  id_rs1,
  input  logic [RW-1:0]  id_rs2,
  input  logic [RW-1:0]  id_rd1,
  input  logic [RW-1:0]  id_rd2,
  input  logic           id_reg_write,
  input  logic           id_write_op2,
  input  logic           id_mem_read,
  input  logic           id_mem_write,
  input  logic [OPW-1:0] id_alu_op,
  input  logic [DW-1:0]  id_imm,
  input  logic [DW-1:0]  rf_rdata1,
  input  logic [DW-1:0]  rf_rdata2,
  input  logic           mem_valid,
  input  logic           mem_reg_write,
  input  logic [RW-1:0]  mem_rd,
  input  logic [DW-1:0]  mem_result,
  input  logic           wb_valid,
  input  logic           wb_reg_write,
  input  logic           wb_write_op2,
  input  logic [RW-1:0]  wb_rd1,
  input  logic [RW-1:0]  wb_rd2,
  input  logic [DW-1:0]  wb_data1,
  input  logic [DW-1:0]  wb_data2,
  input  logic           flush,
  input  logic           hold,
  output logic           stall_o,
  output logic           ex_valid,
  output logic [DW-1:0]  ex_op_a,
  output logic [DW-1:0]  ex_op_b,
  output logic [DW-1:0]  ex_imm,
  output logic [OPW-1:0] ex_alu_op,
  output logic [RW-1:0]  ex_rd1,
  output logic [RW-1:0]  ex_rd2,
  output logic           ex_reg_write,
  output logic           ex_write_op2,
  output logic           ex_mem_read,
  output logic           ex_mem_write
);

  logic          valid_q, valid_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [DW-1:0] op_a_q, op_a_d;
  logic [DW-1:0] op_b_q, op_b_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [RW-1:0] rd1_q, rd1_d;
  logic [RW-1:0] rd2_q, rd2_d;

  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;
  ctrl_t         id_ctrl;
  logic          hazard;

  operand_fwd_mux u_fwd_a (
    .rs_i            (id_rs1),
    .rf_data_i       (rf_rdata1),
    .mem_valid_i     (mem_valid),
    .mem_reg_write_i (mem_reg_write),
    .mem_rd_i        (mem_rd),
    .mem_result_i    (mem_result),
    .wb_valid_i      (wb_valid),
    .wb_reg_write_i  (wb_reg_write),
    .wb_write_op2_i  (wb_write_op2),
    .wb_rd1_i        (wb_rd1),
    .wb_rd2_i        (wb_rd2),
    .wb_data1_i      (wb_data1),
    .wb_data2_i      (wb_data2),
    .data_o          (fwd_a)
  );

  operand_fwd_mux u_fwd_b (
    .rs_i            (id_rs2),
    .rf_data_i       (rf_rdata2),
    .mem_valid_i     (mem_valid),
    .mem_reg_write_i (mem_reg_write),
    .mem_rd_i        (mem_rd),
    .mem_result_i    (mem_result),
    .wb_valid_i      (wb_valid),
    .wb_reg_write_i  (wb_reg_write),
    .wb_write_op2_i  (wb_write_op2),
    .wb_rd1_i        (wb_rd1),
    .wb_rd2_i        (wb_rd2),
    .wb_data1_i      (wb_data1),
    .wb_data2_i      (wb_data2),
    .data_o          (fwd_b)
  );

  // Invalid slots must never carry a live write or memory enable.
  always_comb begin
    id_ctrl.reg_write = id_reg_write & id_valid;
    id_ctrl.write_op2 = id_write_op2 & id_valid;
    id_ctrl.mem_read  = id_mem_read  & id_valid;
    id_ctrl.mem_write = id_mem_write & id_valid;
    id_ctrl.alu_op    = id_alu_op;
  end

  assign hazard = valid_q & ctrl_q.mem_read & ctrl_q.reg_write
                & id_valid
                & ((rd1_q == id_rs1) | (rd1_q == id_rs2));

  assign stall_o = hazard & ~hold & ~flush & ~rst;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    imm_d   = imm_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    if (flush || (!hold && hazard)) begin
      valid_d = 1'b0;
      ctrl_d  = ctrl_bubble();
      op_a_d  = '0;
      op_b_d  = '0;
      imm_d   = '0;
      rd1_d   = '0;
      rd2_d   = '0;
    end else if (!hold) begin
      valid_d = id_valid;
      ctrl_d  = id_ctrl;
      op_a_d  = fwd_a;
      op_b_d  = fwd_b;
      imm_d   = id_imm;
      rd1_d   = id_rd1;
      rd2_d   = id_rd2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      imm_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      imm_q   <= imm_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_op_a      = op_a_q;
  assign ex_op_b      = op_b_q;
  assign ex_imm       = imm_q;
  assign ex_alu_op    = ctrl_q.alu_op;
  assign ex_rd1       = rd1_q;
  assign ex_rd2       = rd2_q;
  assign ex_reg_write = ctrl_q.reg_write;
  assign ex_write_op2 = ctrl_q.write_op2;
  assign ex_mem_read  = ctrl_q.mem_read;
  assign ex_mem_write = ctrl_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and random checks of id_ex_stage against a
// cycle-level behavioural model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_rs1, id_rs2, id_rd1, id_rd2;
  logic        id_reg_write, id_write_op2;
  logic        id_mem_read, id_mem_write;
  logic [3:0]  id_alu_op;
  logic [15:0] id_imm, rf_rdata1, rf_rdata2;
  logic        mem_valid, mem_reg_write;
  logic [3:0]  mem_rd;
  logic [15:0] mem_result;
  logic        wb_valid, wb_reg_write, wb_write_op2;
  logic [3:0]  wb_rd1, wb_rd2;
  logic [15:0] wb_data1, wb_data2;
  logic        flush, hold;
  logic        stall_o, ex_valid;
  logic [15:0] ex_op_a, ex_op_b, ex_imm;
  logic [3:0]  ex_alu_op, ex_rd1, ex_rd2;
  logic        ex_reg_write, ex_write_op2;
  logic        ex_mem_read, ex_mem_write;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_reg_write(id_reg_write),
    .id_write_op2(id_write_op2),
    .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write),
    .id_alu_op(id_alu_op), .id_imm(id_imm),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .mem_valid(mem_valid),
    .mem_reg_write(mem_reg_write),
    .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_write_op2(wb_write_op2),
    .wb_rd1(wb_rd1), .wb_rd2(wb_rd2),
    .wb_data1(wb_data1), .wb_data2(wb_data2),
    .flush(flush), .hold(hold),
    .stall_o(stall_o), .ex_valid(ex_valid),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_imm(ex_imm), .ex_alu_op(ex_alu_op),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_reg_write(ex_reg_write),
    .ex_write_op2(ex_write_op2),
    .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model of the EX slot
  logic        m_valid, m_rw, m_wo2, m_mr, m_mw;
  logic [3:0]  m_alu, m_rd1, m_rd2;
  logic [15:0] m_a, m_b, m_imm;
  logic        m_known;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fwd(input logic [3:0] rs,
                                      input logic [15:0] rf);
    if (mem_valid && mem_reg_write && mem_rd == rs)
      return mem_result;
    if (wb_valid && wb_reg_write && wb_rd1 == rs)
      return wb_data1;
    if (wb_valid && wb_reg_write && wb_write_op2 && wb_rd2 == rs)
      return wb_data2;
    return rf;
  endfunction

  function automatic logic m_hazard();
    return m_valid && m_mr && m_rw && id_valid &&
           (m_rd1 == id_rs1 || m_rd1 == id_rs2);
  endfunction

  function automatic logic exp_stall();
    return !rst && m_hazard() && !hold && !flush;
  endfunction

  task automatic m_bubble();
    {m_valid, m_rw, m_wo2, m_mr, m_mw} = '0;
    m_alu = '0; m_rd1 = '0; m_rd2 = '0;
    m_a = '0; m_b = '0; m_imm = '0;
    m_known = 1'b1;
  endtask

  task automatic model_step();
    if (rst || flush) m_bubble();
    else if (hold) begin end
    else if (m_hazard()) m_bubble();
    else begin
      m_a     = fwd(id_rs1, rf_rdata1);
      m_b     = fwd(id_rs2, rf_rdata2);
      m_valid = id_valid;
      m_rw    = id_reg_write && id_valid;
      m_wo2   = id_write_op2 && id_valid;
      m_mr    = id_mem_read && id_valid;
      m_mw    = id_mem_write && id_valid;
      m_alu   = id_alu_op;
      m_rd1   = id_rd1;
      m_rd2   = id_rd2;
      m_imm   = id_imm;
      m_known = id_valid;
    end
  endtask

  task automatic check_ex();
    chk("ex_valid", 16'(ex_valid), 16'(m_valid));
    chk("ex_reg_write", 16'(ex_reg_write), 16'(m_rw));
    chk("ex_write_op2", 16'(ex_write_op2), 16'(m_wo2));
    chk("ex_mem_read", 16'(ex_mem_read), 16'(m_mr));
    chk("ex_mem_write", 16'(ex_mem_write), 16'(m_mw));
    if (m_known) begin
      chk("ex_op_a", ex_op_a, m_a);
      chk("ex_op_b", ex_op_b, m_b);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_alu_op", 16'(ex_alu_op), 16'(m_alu));
      chk("ex_rd1", 16'(ex_rd1), 16'(m_rd1));
      chk("ex_rd2", 16'(ex_rd2), 16'(m_rd2));
    end
  endtask

  task automatic cycle();
    #1;
    chk("stall_o", 16'(stall_o), 16'(exp_stall()));
    model_step();
    @(posedge clk);
    #1;
    check_ex();
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0;
    id_rd1 = 0; id_rd2 = 0;
    id_reg_write = 0; id_write_op2 = 0;
    id_mem_read = 0; id_mem_write = 0;
    id_alu_op = 0; id_imm = 0;
    rf_rdata1 = 0; rf_rdata2 = 0;
    mem_valid = 0; mem_reg_write = 0;
    mem_rd = 0; mem_result = 0;
    wb_valid = 0; wb_reg_write = 0; wb_write_op2 = 0;
    wb_rd1 = 0; wb_rd2 = 0; wb_data1 = 0; wb_data2 = 0;
    flush = 0; hold = 0;
  endtask

  task automatic issue(input logic [3:0] rs1,
                       input logic [3:0] rs2,
                       input logic [3:0] rd1);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2;
    id_rd1 = rd1; id_rd2 = 4'hE;
    id_reg_write = 1; id_alu_op = 4'h3;
    id_imm = 16'h1234;
    rf_rdata1 = 16'h1111; rf_rdata2 = 16'h2222;
  endtask

  task automatic randomize_inputs();
    int r;
    id_valid     = ($urandom_range(0, 9) < 8);
    id_rs1       = 4'($urandom_range(0, 7));
    id_rs2       = 4'($urandom_range(0, 7));
    id_rd1       = 4'($urandom_range(0, 7));
    id_rd2       = 4'($urandom_range(0, 15));
    id_reg_write = 1'($urandom);
    id_write_op2 = 1'($urandom);
    id_mem_read  = ($urandom_range(0, 9) < 3);
    id_mem_write = 1'($urandom);
    id_alu_op    = 4'($urandom);
    id_imm       = 16'($urandom);
    rf_rdata1    = 16'($urandom);
    rf_rdata2    = 16'($urandom);
    mem_valid    = 1'($urandom);
    mem_reg_write = 1'($urandom);
    mem_rd       = 4'($urandom_range(0, 7));
    mem_result   = 16'($urandom);
    wb_valid     = 1'($urandom);
    wb_reg_write = 1'($urandom);
    wb_write_op2 = 1'($urandom);
    wb_rd1       = 4'($urandom_range(0, 7));
    r            = $urandom_range(1, 7);
    wb_rd2       = 4'((int'(wb_rd1) + r) % 8);
    wb_data1     = 16'($urandom);
    wb_data2     = 16'($urandom);
    flush        = ($urandom_range(0, 9) == 0);
    hold         = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    idle();
    rst = 1;
    m_bubble();
    #1;
    check_ex();
    chk("rst_stall", 16'(stall_o), 16'h0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // MEM forward beats register file
    issue(4'd2, 4'd7, 4'd9);
    rf_rdata1 = 16'h0001;
    mem_valid = 1; mem_reg_write = 1;
    mem_rd = 4'd2; mem_result = 16'h0002;
    cycle();
    chk("mem_fwd", ex_op_a, 16'h0002);

    // WB dual write, then MEM overrides WB port 2
    idle();
    issue(4'd5, 4'd4, 4'd1);
    wb_valid = 1; wb_reg_write = 1; wb_write_op2 = 1;
    wb_rd1 = 4'd4; wb_data1 = 16'h0FF0;
    wb_rd2 = 4'd5; wb_data2 = 16'h00AA;
    cycle();
    chk("wb2_fwd", ex_op_a, 16'h00AA);
    chk("wb1_fwd", ex_op_b, 16'h0FF0);
    mem_valid = 1; mem_reg_write = 1;
    mem_rd = 4'd5; mem_result = 16'hF0F0;
    cycle();
    chk("mem_over_wb", ex_op_a, 16'hF0F0);
    chk("wb1_kept", ex_op_b, 16'h0FF0);

    // R0 forwards like any register
    idle();
    issue(4'd0, 4'd0, 4'd1);
    mem_valid = 1; mem_reg_write = 1;
    mem_rd = 4'd0; mem_result = 16'hBEEF;
    cycle();
    chk("r0_fwd", ex_op_b, 16'hBEEF);

    // load-use: stall then issue
    idle();
    issue(4'd1, 4'd6, 4'd3);
    id_mem_read = 1;
    cycle();
    issue(4'd8, 4'd3, 4'd4);
    #1;
    chk("lu_stall", 16'(stall_o), 16'h1);
    cycle();
    chk("lu_bubble", 16'(ex_valid), 16'h0);
    cycle();
    chk("lu_issue", 16'(ex_valid), 16'h1);
    chk("lu_issue_rd", 16'(ex_rd1), 16'h4);

    // flush beats hold
    flush = 1; hold = 1;
    cycle();
    chk("flush_hold", 16'(ex_valid), 16'h0);
    flush = 0; hold = 0;
    issue(4'd2, 4'd3, 4'd7);
    id_imm = 16'h5A5A;
    cycle();
    hold = 1;
    idle();
    hold = 1;
    issue(4'd9, 4'd9, 4'd9);
    id_imm = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_imm", ex_imm, 16'h5A5A);
      chk("hold_stall", 16'(stall_o), 16'h0);
    end

    // invalid slot never writes
    idle();
    id_reg_write = 1; id_mem_write = 1;
    cycle();
    chk("inv_rw", 16'(ex_reg_write), 16'h0);
    chk("inv_valid", 16'(ex_valid), 16'h0);

    // asynchronous reset mid-stream
    issue(4'd1, 4'd2, 4'd3);
    id_mem_read = 1;
    cycle();
    issue(4'd3, 4'd3, 4'd5);
    #2;
    rst = 1;
    m_bubble();
    #1;
    chk("arst_valid", 16'(ex_valid), 16'h0);
    chk("arst_rw", 16'(ex_reg_write), 16'h0);
    chk("arst_mr", 16'(ex_mem_read), 16'h0);
    chk("arst_rd1", 16'(ex_rd1), 16'h0);
    chk("arst_imm", ex_imm, 16'h0);
    chk("arst_stall", 16'(stall_o), 16'h0);
    @(negedge clk);
    cycle();
    rst = 0;

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
